// File: rtl/t03_nes_pkg.sv
// t03_nes_pkg: poll FSM states, button bit indices and pad width shared by the NES pad reader
package t03_nes_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} nes_state_t;
  localparam int NES_BITS = 8;
  localparam int BTN_A = 0, BTN_B = 1, BTN_SELECT = 2, BTN_START = 3;
  localparam int BTN_UP = 4, BTN_DOWN = 5, BTN_LEFT = 6, BTN_RIGHT = 7;
endpackage

// File: rtl/nes_sync.sv
// nes_sync: 2-flop synchronizer for an active-low pad line; resets to 1 (released)
module nes_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls two NES pads over a shared latch/pulse bus and commits an 8+8 button snapshot.
// Define NES_DEBOUNCE_EN to commit a pad's byte only when two consecutive frames agree.
module nes_pad_reader import t03_nes_pkg::*; #(
  parameter int LATCH_CYCLES = 120,
  parameter int HALF_CYCLES  = 60,
  parameter int POLL_CYCLES  = 166667
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1_serial,
  input  logic        p2_serial,
  output logic        nes_latch,
  output logic        nes_pulse,
  output logic [31:0] nes_data,
  output logic        nes_confirm,
  output logic        nes_update
);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES);
  localparam int IW = $clog2(NES_BITS);
  nes_state_t state, nstate;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cyc;
  logic [IW-1:0] idx;
  logic [NES_BITS-1:0] cap1, cap2;
  logic s1, s2, wrap, last_latch, last_half, commit, both_ok;
  logic [31:0] new_data;
  nes_sync u_sync1 (.clk(clk), .rst(rst), .d(p1_serial), .q(s1));
  nes_sync u_sync2 (.clk(clk), .rst(rst), .d(p2_serial), .q(s2));
  always_comb begin
    wrap       = poll_cnt == PW'(POLL_CYCLES - 1);
    last_latch = cyc == CW'(LATCH_CYCLES - 1);
    last_half  = cyc == CW'(HALF_CYCLES - 1);
    commit     = state == DONE;
    nstate     = state;
    unique case (state)
      IDLE:    if (wrap) nstate = LATCH;
      LATCH:   if (last_latch) nstate = LOW;
      LOW:     if (last_half) nstate = idx == IW'(BTN_RIGHT) ? DONE : HIGH;
      HIGH:    if (last_half) nstate = LOW;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
`ifdef NES_DEBOUNCE_EN
  logic [NES_BITS-1:0] prev1, prev2;
  logic prev_vld, m1, m2;
  always_comb begin
    m1       = prev_vld && cap1 == prev1;
    m2       = prev_vld && cap2 == prev2;
    both_ok  = m1 && m2;
    new_data = {16'h0, m2 ? cap2 : nes_data[15:8], m1 ? cap1 : nes_data[7:0]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {prev_vld, prev2, prev1} <= '0;
    else if (commit) {prev_vld, prev2, prev1} <= {1'b1, cap2, cap1};
`else
  always_comb begin
    both_ok  = 1'b1;
    new_data = {16'h0, cap2, cap1};
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      poll_cnt    <= '0;
      cyc         <= '0;
      idx         <= '0;
      cap1        <= '0;
      cap2        <= '0;
      nes_latch   <= 1'b0;
      nes_pulse   <= 1'b0;
      nes_data    <= '0;
      nes_confirm <= 1'b0;
      nes_update  <= 1'b0;
    end else begin
      state      <= nstate;
      poll_cnt   <= wrap ? '0 : poll_cnt + 1'b1;
      cyc        <= nstate != state ? '0 : cyc + 1'b1;
      nes_latch  <= nstate == LATCH;
      nes_pulse  <= nstate == HIGH;
      nes_update <= commit && new_data != nes_data;
      if (state == LATCH) idx <= IW'(BTN_A);
      else if (state == HIGH && last_half) idx <= idx + 1'b1;
      // first-sampled bit (A) ends up in bit 0
      if (state == LOW && last_half) begin
        cap1 <= {~s1, cap1[NES_BITS-1:1]};
        cap2 <= {~s2, cap2[NES_BITS-1:1]};
      end
      if (commit) begin
        nes_data    <= new_data;
        nes_confirm <= nes_confirm | both_ok;
      end
    end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: random pad stimulus against a frame-level model of nes_pad_reader
module tb_nes_pad_reader;
  logic clk = 1'b0, rst = 1'b1;
  logic p1_serial, p2_serial, nes_latch, nes_pulse, nes_confirm, nes_update;
  logic [31:0] nes_data;
  int total = 0, bad = 0, tcyc = 0, first_lat = 0;
  logic [7:0] btn1 = '0, btn2 = '0, sh1 = '0, sh2 = '0;
  logic pulse_d = 1'b0;
  logic [31:0] exp_data = '0;
  logic exp_conf = 1'b0;
`ifdef NES_DEBOUNCE_EN
  logic [7:0] prev1 = '0, prev2 = '0;
  logic prev_vld = 1'b0;
`endif
  nes_pad_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(4), .POLL_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .p1_serial(p1_serial), .p2_serial(p2_serial),
    .nes_latch(nes_latch), .nes_pulse(nes_pulse), .nes_data(nes_data),
    .nes_confirm(nes_confirm), .nes_update(nes_update)
  );
  always #5 clk = ~clk;
  assign p1_serial = ~sh1[0];
  assign p2_serial = ~sh2[0];
  // pad model: parallel load while latched, shift on pulse rising edge
  always @(negedge clk) begin
    pulse_d <= nes_pulse;
    if (nes_latch) begin
      sh1 <= btn1;
      sh2 <= btn2;
    end else if (nes_pulse && !pulse_d) begin
      sh1 <= {1'b0, sh1[7:1]};
      sh2 <= {1'b0, sh2[7:1]};
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask
  task automatic model_reset();
    exp_data = '0;
    exp_conf = 1'b0;
`ifdef NES_DEBOUNCE_EN
    prev1 = '0;
    prev2 = '0;
    prev_vld = 1'b0;
`endif
  endtask
  task automatic model_commit(input logic [7:0] b1, input logic [7:0] b2);
`ifdef NES_DEBOUNCE_EN
    logic m1, m2;
    m1 = prev_vld && b1 == prev1;
    m2 = prev_vld && b2 == prev2;
    if (m1) exp_data[7:0] = b1;
    if (m2) exp_data[15:8] = b2;
    if (m1 && m2) exp_conf = 1'b1;
    prev1 = b1;
    prev2 = b2;
    prev_vld = 1'b1;
`else
    exp_data = {16'h0, b2, b1};
    exp_conf = 1'b1;
`endif
  endtask
  task automatic wait_latch();
    int n = 0;
    while (!nes_latch && n < 250) begin
      tick();
      n++;
    end
    chk("latch_seen", {31'h0, nes_latch}, 32'h1);
    chk("latch_phase", tcyc % 200, 0);
    first_lat = tcyc;
  endtask
  task automatic run_frame(input logic [7:0] b1, input logic [7:0] b2);
    logic [31:0] old_data;
    logic old_conf, pp;
    int lat = 0, rises = 0, hi = 0, first_rise = -1, upd = 0, upd_at = -1;
    btn1 = b1;
    btn2 = b2;
    old_data = exp_data;
    old_conf = exp_conf;
    model_commit(b1, b2);
    wait_latch();
    pp = 1'b0;
    for (int off = 0; off <= 66; off++) begin
      if (off > 0) tick();
      lat += int'(nes_latch);
      hi += int'(nes_pulse);
      if (nes_pulse && !pp) begin
        rises++;
        if (first_rise < 0) first_rise = off;
      end
      pp = nes_pulse;
      if (nes_update) begin
        upd++;
        upd_at = off;
      end
      if (off == 64) begin
        chk("data_pre", nes_data, old_data);
        chk("conf_pre", {31'h0, nes_confirm}, {31'h0, old_conf});
      end
      if (off == 65) begin
        chk("data", nes_data, exp_data);
        chk("conf", {31'h0, nes_confirm}, {31'h0, exp_conf});
        chk("upper", {16'h0, nes_data[31:16]}, 32'h0);
      end
    end
    chk("latch_len", lat, 4);
    chk("pulse_cnt", rises, 7);
    chk("pulse_hi", hi, 28);
    chk("pulse_first", first_rise, 8);
    chk("upd_cnt", upd, exp_data != old_data ? 1 : 0);
    chk("upd_at", upd_at, exp_data != old_data ? 65 : -1);
  endtask
  initial begin
    logic [7:0] r1, r2;
    repeat (3) tick();
    chk("rst_data", nes_data, 32'h0);
    chk("rst_ctl", {28'h0, nes_latch, nes_pulse, nes_confirm, nes_update}, 32'h0);
    rst = 1'b0;
    tcyc = 0;
    run_frame(8'h09, 8'h40);
    chk("t1_first_latch", first_lat, 200);
`ifndef NES_DEBOUNCE_EN
    chk("t2_data", nes_data, 32'h0000_4009);
`endif
    run_frame(8'h09, 8'h40);
    r1 = 8'h09;
    r2 = 8'h40;
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) r1 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) r2 = 8'($urandom);
      run_frame(r1, r2);
    end
    run_frame(8'hFF, 8'hFF);
    run_frame(8'hFF, 8'hFF);
    chk("t6_all", nes_data, 32'h0000_FFFF);
    btn1 = 8'h5A;
    btn2 = 8'hA5;
    wait_latch();
    repeat (33) tick();
    chk("t4_in_high", {31'h0, nes_pulse}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_data", nes_data, 32'h0);
    chk("t4_rst_ctl", {28'h0, nes_latch, nes_pulse, nes_confirm, nes_update}, 32'h0);
    tick();
    rst = 1'b0;
    tcyc = 0;
    model_reset();
    run_frame(8'h01, 8'h00);
    chk("t4_relatch", first_lat, 200);
`ifdef NES_DEBOUNCE_EN
    chk("t5_f1", {24'h0, nes_data[7:0]}, 32'h0);
    run_frame(8'h02, 8'h00);
    chk("t5_f2", {24'h0, nes_data[7:0]}, 32'h0);
    chk("t5_conf2", {31'h0, nes_confirm}, 32'h0);
    run_frame(8'h02, 8'h00);
    chk("t5_f3", {24'h0, nes_data[7:0]}, 32'h02);
    chk("t5_conf3", {31'h0, nes_confirm}, 32'h1);
`else
    chk("t4_conf", {31'h0, nes_confirm}, 32'h1);
    run_frame(8'h02, 8'h00);
    run_frame(8'h02, 8'h00);
    chk("t5_nodeb", {24'h0, nes_data[7:0]}, 32'h02);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
